simple_fetch: RTL and testbench

Instruction fetch/issue unit: the producer side of the 16-bit `instruction_wire` consumed by `simple_top`.
- Accepts a program over a valid/ready load port into a local instruction memory.
- On command, streams the program to the decoder over a valid/ready issue port.
- Handles the control-flow opcodes (JMP, HALT) internally, so the decoder only sees ALU/RF instructions.
- Sits between the test/loader harness and `simple_top` in the simple datapath.

---
 rtl/simple_pkg.sv | 24 ++
 rtl/simple_fetch_if.sv | 35 +++
 rtl/simple_imem.sv | 31 +++
 rtl/simple_fetch.sv | 152 +++++++++++++++
 tb/tb_simple_fetch.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/simple_pkg.sv
// ============================================================================
// Module  : simple_pkg
// Brief   : Shared opcodes, field bounds and fetch FSM state type.
// Revision: 1.0
// ============================================================================
`default_nettype none

package simple_pkg;

    localparam int          OPC_HI  = 15;
    localparam int          OPC_LO  = 13;
    localparam logic [2:0]  OP_JMP  = 3'b110;
    localparam logic [2:0]  OP_HALT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        HALT = 2'd3
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/simple_fetch_if.sv
// ============================================================================
// Module  : simple_fetch_if
// Brief   : Load port, run control and issue port of the fetch unit.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface simple_fetch_if #(
    parameter int AW = 5
);
    logic          load_start;
    logic          load_valid;
    logic [15:0]   load_data;
    logic          load_last;
    logic          load_ready;
    logic          run_start;
    logic          instr_valid;
    logic          instr_ready;
    logic [15:0]   instruction_wire;
    logic [AW-1:0] pc;
    logic          busy;
    logic          halted;

    modport master (
        output load_start, load_valid, load_data, load_last, run_start, instr_ready,
        input  load_ready, instr_valid, instruction_wire, pc, busy, halted
    );

    modport slave (
        input  load_start, load_valid, load_data, load_last, run_start, instr_ready,
        output load_ready, instr_valid, instruction_wire, pc, busy, halted
    );
endinterface

`default_nettype wire

// File: rtl/simple_imem.sv
// ============================================================================
// Module  : simple_imem
// Brief   : DEPTH x 16 instruction memory, one write and one registered read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module simple_imem #(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic          clk,
    input  wire logic          i_we,
    input  wire logic [AW-1:0] i_waddr,
    input  wire logic [15:0]   i_wdata,
    input  wire logic [AW-1:0] i_raddr,
    output logic      [15:0]   o_rdata
);

    logic [15:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        o_rdata <= r_mem[i_raddr];
    end

endmodule

`default_nettype wire

// File: rtl/simple_fetch.sv
// ============================================================================
// Module  : simple_fetch
// Brief   : Program loader and instruction issue unit with JMP/HALT handling.
// Revision: 1.0
// ============================================================================
`default_nettype none

module simple_fetch
    import simple_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  wire logic       clk,
    input  wire logic       rst,
    simple_fetch_if.slave   bus
);

    fetch_state_t  r_state, w_state_nxt;
    logic [AW-1:0] r_wptr;
    logic [AW:0]   r_prog_len, r_fpc, w_faddr;
    logic          r_rd_vld, r_rd_oob, r_halt_pend;
    logic [AW-1:0] r_rd_pc;
    logic [15:0]   w_rdata;
    logic          r_out_vld, r_sk_vld;
    logic [15:0]   r_out_data, r_sk_data;
    logic [AW-1:0] r_out_pc, r_sk_pc;
    logic          w_load_beat, w_load_end, w_run_go, w_hs, w_drained;
    logic          w_rd_halt, w_rd_jmp, w_rd_word, w_halt_now;
    logic          w_fetch_run, w_fetch;
    logic [1:0]    w_occ_nxt;
    logic [2:0]    w_opc;

    assign w_opc       = w_rdata[OPC_HI:OPC_LO];
    assign w_load_beat = (r_state == LOAD) && bus.load_valid;
    assign w_load_end  = w_load_beat && (bus.load_last || r_wptr == AW'(DEPTH-1));
    assign w_run_go    = !bus.load_start && bus.run_start &&
                         ((r_state == IDLE && r_prog_len != '0) || r_state == HALT);

    // An out-of-range fetch behaves exactly like a HALT word.
    assign w_rd_halt  = (r_state == RUN) && r_rd_vld && (r_rd_oob || w_opc == OP_HALT);
    assign w_rd_jmp   = (r_state == RUN) && r_rd_vld && !r_rd_oob && w_opc == OP_JMP;
    assign w_rd_word  = (r_state == RUN) && r_rd_vld && !w_rd_halt && !w_rd_jmp;
    assign w_halt_now = r_halt_pend || w_rd_halt;
    assign w_hs       = r_out_vld && bus.instr_ready;
    assign w_drained  = !r_sk_vld && (!r_out_vld || w_hs);

    // A fetch issued now lands next cycle, so it needs a free slot then.
    assign w_occ_nxt   = 2'(r_out_vld) + 2'(r_sk_vld) - 2'(w_hs) + 2'(w_rd_word);
    assign w_fetch_run = (r_state == RUN) && !w_halt_now && !w_rd_jmp && (w_occ_nxt <= 2'd1);
    assign w_fetch     = w_run_go || w_fetch_run;
    assign w_faddr     = w_run_go ? '0 : r_fpc;

    simple_imem #(.DEPTH(DEPTH), .AW(AW)) u_imem (
        .clk     (clk),
        .i_we    (w_load_beat),
        .i_waddr (r_wptr),
        .i_wdata (bus.load_data),
        .i_raddr (w_faddr[AW-1:0]),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (bus.load_start) w_state_nxt = LOAD;
                  else if (w_run_go)  w_state_nxt = RUN;
            LOAD: if (w_load_end)     w_state_nxt = IDLE;
            RUN:  if (w_halt_now && w_drained) w_state_nxt = HALT;
            HALT: if (bus.load_start) w_state_nxt = LOAD;
                  else if (w_run_go)  w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.load_ready       = (r_state == LOAD);
        bus.busy             = (r_state == LOAD) || (r_state == RUN);
        bus.halted           = (r_state == HALT);
        bus.instr_valid      = r_out_vld;
        bus.instruction_wire = r_out_data;
        bus.pc               = r_out_pc;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr      <= '0;
            r_prog_len  <= '0;
            r_fpc       <= '0;
            r_rd_vld    <= 1'b0;
            r_rd_oob    <= 1'b0;
            r_rd_pc     <= '0;
            r_halt_pend <= 1'b0;
        end else begin
            if ((r_state == IDLE || r_state == HALT) && bus.load_start) begin
                r_wptr <= '0;
            end else if (w_load_beat) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_load_end) begin
                r_prog_len <= {1'b0, r_wptr} + 1'b1;
            end
            if (w_run_go)         r_fpc <= (AW+1)'(1);
            else if (w_rd_jmp)    r_fpc <= {1'b0, w_rdata[AW-1:0]};
            else if (w_fetch_run) r_fpc <= r_fpc + 1'b1;
            r_rd_vld    <= w_fetch;
            r_rd_pc     <= w_faddr[AW-1:0];
            r_rd_oob    <= (w_faddr >= r_prog_len);
            r_halt_pend <= (r_state == RUN) && w_halt_now && !w_drained;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_vld  <= 1'b0;
            r_out_data <= '0;
            r_out_pc   <= '0;
            r_sk_vld   <= 1'b0;
            r_sk_data  <= '0;
            r_sk_pc    <= '0;
        end else if (!r_out_vld || w_hs) begin
            if (r_sk_vld) begin
                r_out_vld  <= 1'b1;
                r_out_data <= r_sk_data;
                r_out_pc   <= r_sk_pc;
                r_sk_vld   <= w_rd_word;
                if (w_rd_word) begin
                    r_sk_data <= w_rdata;
                    r_sk_pc   <= r_rd_pc;
                end
            end else begin
                r_out_vld <= w_rd_word;
                if (w_rd_word) begin
                    r_out_data <= w_rdata;
                    r_out_pc   <= r_rd_pc;
                end
            end
        end else if (w_rd_word) begin
            r_sk_vld  <= 1'b1;
            r_sk_data <= w_rdata;
            r_sk_pc   <= r_rd_pc;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_simple_fetch.sv
// ============================================================================
// Module  : tb_simple_fetch
// Brief   : Scoreboard bench for simple_fetch load, issue, JMP, HALT and reset.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_simple_fetch;

    typedef struct packed {
        logic [15:0] data;
        logic [4:0]  pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_hs_cyc = 0;
    int          halt_cyc = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          hs_cyc_q[$];
    logic [15:0] prog_q[$];
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;
    logic [4:0]  prev_pc = '0;

    simple_fetch_if #(.AW(5)) bus ();

    simple_fetch #(.DEPTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] d, input logic [4:0] p);
        exp_t e;
        e.data = d;
        e.pc   = p;
        exp_q.push_back(e);
    endtask

    // Issue monitor: pops the scoreboard on each handshake, checks hold while stalled.
    always @(negedge clk) begin
        if (prev_stall) begin
            check_val("hold_valid", 32'(bus.instr_valid), 32'd1);
            check_val("hold_data", 32'(bus.instruction_wire), 32'(prev_data));
            check_val("hold_pc", 32'(bus.pc), 32'(prev_pc));
        end
        if (rst && bus.instr_valid && bus.instr_ready) begin
            hs_cyc_q.push_back(cyc);
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_val("extra_issue", 32'(bus.instruction_wire), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("issue_data", 32'(bus.instruction_wire), 32'(mon_e.data));
                check_val("issue_pc", 32'(bus.pc), 32'(mon_e.pc));
            end
        end
        prev_stall = rst && bus.instr_valid && !bus.instr_ready;
        prev_data  = bus.instruction_wire;
        prev_pc    = bus.pc;
    end

    task automatic load_prog(input bit use_last);
        bus.load_start = 1'b1;
        tick();
        bus.load_start = 1'b0;
        check_val("load_ready_rise", 32'(bus.load_ready), 32'd1);
        foreach (prog_q[i]) begin
            bus.load_valid = 1'b1;
            bus.load_data  = prog_q[i];
            bus.load_last  = use_last && (i == prog_q.size() - 1);
            tick();
        end
        bus.load_valid = 1'b0;
        bus.load_last  = 1'b0;
        check_val("load_ready_fall", 32'(bus.load_ready), 32'd0);
        check_val("load_busy_clr", 32'(bus.busy), 32'd0);
    endtask

    task automatic run_prog(input bit toggle);
        bit seen;
        seen = 1'b0;
        hs_cyc_q.delete();
        bus.instr_ready = toggle ? 1'b0 : 1'b1;
        bus.run_start = 1'b1;
        tick();
        bus.run_start = 1'b0;
        check_val("first_lat_n1", 32'(bus.instr_valid), 32'd0);
        tick();
        check_val("first_lat_n2", 32'(bus.instr_valid), 32'd1);
        for (int k = 0; k < 200 && !seen; k++) begin
            if (bus.halted) begin
                seen = 1'b1;
                halt_cyc = cyc;
            end else begin
                bus.instr_ready = toggle ? ~bus.instr_ready : 1'b1;
                tick();
            end
        end
        check_val("halt_reached", 32'(seen), 32'd1);
        if (seen) check_val("halt_lat", 32'(halt_cyc - last_hs_cyc), 32'd1);
        check_val("halt_no_valid", 32'(bus.instr_valid), 32'd0);
        check_val("sb_empty", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_ignored_run(input string tag);
        bus.run_start = 1'b1;
        tick();
        bus.run_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_val({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
            check_val({tag, "_busy"}, 32'(bus.busy), 32'd0);
            tick();
        end
    endtask

    initial begin
        bus.load_start  = 1'b0;
        bus.load_valid  = 1'b0;
        bus.load_data   = '0;
        bus.load_last   = 1'b0;
        bus.run_start   = 1'b0;
        bus.instr_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        check_val("rst_load_ready", 32'(bus.load_ready), 32'd0);
        check_val("rst_valid", 32'(bus.instr_valid), 32'd0);
        check_val("rst_instr", 32'(bus.instruction_wire), 32'd0);
        check_val("rst_pc", 32'(bus.pc), 32'd0);
        check_val("rst_busy", 32'(bus.busy), 32'd0);
        check_val("rst_halted", 32'(bus.halted), 32'd0);

        check_ignored_run("empty_run");

        // Basic program ending in HALT, full throughput
        prog_q = '{16'h2001, 16'h4002, 16'h6003, 16'hE000};
        load_prog(1'b1);
        push_exp(16'h2001, 5'd0);
        push_exp(16'h4002, 5'd1);
        push_exp(16'h6003, 5'd2);
        run_prog(1'b0);
        check_val("thru_count", 32'(hs_cyc_q.size()), 32'd3);
        for (int i = 1; i < hs_cyc_q.size(); i++)
            check_val("thru_gap", 32'(hs_cyc_q[i] - hs_cyc_q[i-1]), 32'd1);

        // Same program replayed from HALT under alternating backpressure
        push_exp(16'h2001, 5'd0);
        push_exp(16'h4002, 5'd1);
        push_exp(16'h6003, 5'd2);
        run_prog(1'b1);

        // Jump over a word; 32-word load terminates without load_last
        prog_q = '{16'h2001, 16'hC003, 16'h4002, 16'h6003};
        for (int i = 4; i < 32; i++) prog_q.push_back(16'hE000);
        load_prog(1'b0);
        push_exp(16'h2001, 5'd0);
        push_exp(16'h6003, 5'd3);
        run_prog(1'b0);
        check_val("jmp_count", 32'(hs_cyc_q.size()), 32'd2);
        if (hs_cyc_q.size() == 2)
            check_val("jmp_gap", 32'(hs_cyc_q[1] - hs_cyc_q[0]), 32'd3);

        // Fall off the end of a 3-word program, twice
        prog_q = '{16'h2001, 16'h4002, 16'h6003};
        load_prog(1'b1);
        for (int r = 0; r < 2; r++) begin
            push_exp(16'h2001, 5'd0);
            push_exp(16'h4002, 5'd1);
            push_exp(16'h6003, 5'd2);
            run_prog(1'b0);
        end

        // Reset while an instruction is stalled on the issue port
        prog_q = '{16'h2001, 16'h4002, 16'h6003, 16'hE000};
        load_prog(1'b1);
        bus.instr_ready = 1'b0;
        bus.run_start = 1'b1;
        tick();
        bus.run_start = 1'b0;
        for (int k = 0; k < 10 && !bus.instr_valid; k++) tick();
        check_val("pre_rst_valid", 32'(bus.instr_valid), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_val("mid_rst_valid", 32'(bus.instr_valid), 32'd0);
        check_val("mid_rst_instr", 32'(bus.instruction_wire), 32'd0);
        check_val("mid_rst_pc", 32'(bus.pc), 32'd0);
        check_val("mid_rst_busy", 32'(bus.busy), 32'd0);
        check_val("mid_rst_halted", 32'(bus.halted), 32'd0);
        check_val("mid_rst_load_ready", 32'(bus.load_ready), 32'd0);
        check_ignored_run("post_rst_run");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
